chacha_host: RTL and testbench

Initiator for the chacha core's byte-serial port.
- Accepts host commands: load key, load nonce, load counter, read block.
- Buffers each write payload so it is sent to the core as one gap-free burst, then drives the core's strobes (wr_key/wr_nnc/wr_ctr/rd_blk).
- Collects the 64-byte keystream block from the core and streams it out.
- Sits between the top-level pin/host adapter and the chacha core instance.

---
 rtl/chacha_host.sv | 187 ++++++++++++++++++
 tb/tb_chacha_host.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_host.sv
// Host-side initiator for the chacha core's byte-serial port: buffers write
// payloads into gap-free bursts, sequences block reads and streams keystream out.
module chacha_host #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       err,
    input  logic       pause,
    output logic       c_wr_key,
    output logic       c_wr_nnc,
    output logic       c_wr_ctr,
    output logic       c_hold,
    input  logic       c_blk_rdy,
    output logic       c_rd_blk,
    output logic [7:0] c_din,
    input  logic [7:0] c_dout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_BURST,
        ST_WAIT_RDY,
        ST_READ
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [6:0]        rd_cnt_q, rd_cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [7:0]        buf_q [32];
    logic              buf_we;
    logic [5:0]        last_idx;

    // Index of the final payload byte for the latched op
    always_comb begin
        unique case (op_q)
            2'd0:    last_idx = 6'd31;
            2'd1:    last_idx = 6'd11;
            default: last_idx = 6'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q[4:0]] <= in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wait_d      = wait_q;
        err_d       = err_q;
        buf_we      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    rd_cnt_d = '0;
                    wait_d   = '0;
                    state_d  = (cmd_op == 2'd3) ? ST_WAIT_RDY : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = ST_BURST;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_BURST: begin
                if (cnt_q == last_idx) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_WAIT_RDY: begin
                // Ready wins over an expiring timeout in the same cycle
                if (c_blk_rdy) begin
                    state_d = ST_READ;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_READ: begin
                rd_cnt_d = rd_cnt_q + 7'd1;
                if (rd_cnt_q != 7'd0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = c_dout;
                    out_last_d  = (rd_cnt_q == 7'd64);
                end
                if (rd_cnt_q == 7'd64) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        in_ready  = (state_q == ST_FILL);
        c_din     = '0;
        c_wr_key  = 1'b0;
        c_wr_nnc  = 1'b0;
        c_wr_ctr  = 1'b0;
        c_rd_blk  = (state_q == ST_READ) && (rd_cnt_q == 7'd0);
        if (state_q == ST_BURST) begin
            c_din = buf_q[cnt_q[4:0]];
            if (cnt_q == 6'd0) begin
                unique case (op_q)
                    2'd0:    c_wr_key = 1'b1;
                    2'd1:    c_wr_nnc = 1'b1;
                    2'd2:    c_wr_ctr = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign c_hold    = pause;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_chacha_host.sv
// Directed bench for chacha_host: a transaction-level scoreboard checks every
// cycle, while directed steps pin literal values from hand calculation.
module tb_chacha_host;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready, in_valid, in_ready;
    logic [1:0] cmd_op;
    logic [7:0] in_data, out_data, c_din, c_dout;
    logic       out_valid, out_last, busy, err, pause;
    logic       c_wr_key, c_wr_nnc, c_wr_ctr, c_hold, c_blk_rdy, c_rd_blk;

    always #5 clk = ~clk;

    chacha_host #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err), .pause(pause),
        .c_wr_key(c_wr_key), .c_wr_nnc(c_wr_nnc), .c_wr_ctr(c_wr_ctr),
        .c_hold(c_hold), .c_blk_rdy(c_blk_rdy), .c_rd_blk(c_rd_blk),
        .c_din(c_din), .c_dout(c_dout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Core: after a read pulse, byte k of the block is k ^ 0x5A on the k+1-th following cycle
    int core_k = -1;
    initial c_dout = 8'h00;
    always @(posedge clk) begin
        if (c_rd_blk === 1'b1) core_k = 0;
        else if (core_k >= 0 && core_k < 63) core_k = core_k + 1;
        else core_k = -1;
        c_dout <= (core_k >= 0) ? (8'(core_k) ^ 8'h5A) : 8'h00;
    end

    typedef struct { logic [7:0] d; logic [1:0] op; bit first; } bq_t;
    typedef struct { bit v; logic [7:0] d; bit last; } oq_t;

    bq_t        bq[$];
    oq_t        oq[$];
    logic [7:0] pay[$];
    bit         armed = 0, in_fill = 0, waiting = 0, rd_next = 0, exp_err = 0;
    logic [1:0] m_op = 0;
    int         wcnt = 0, cyc = 0, rd_cyc = 0, acc_cyc = 0;
    int         bcnt = 0, ocnt = 0, n_key = 0, n_nnc = 0, n_ctr = 0, rd_pulses = 0;
    logic [7:0] blog [64];
    logic [7:0] olog [64];

    function automatic int plen(input logic [1:0] op);
        return (op == 2'd0) ? 32 : (op == 2'd1) ? 12 : 4;
    endfunction

    always @(negedge clk) begin : mon
        bit  eb;
        bq_t be;
        oq_t oe;
        cyc++;
        if (armed) begin
            eb = in_fill || (bq.size() > 0) || waiting || rd_next || (oq.size() > 1);
            check("cmd_ready", cmd_ready, !eb);
            check("busy", busy, eb);
            check("in_ready", in_ready, in_fill);
            check("err", err, exp_err);
            check("c_hold", c_hold, pause);
            check("c_rd_blk", c_rd_blk, rd_next);
            if (c_wr_key === 1'b1) n_key++;
            if (c_wr_nnc === 1'b1) n_nnc++;
            if (c_wr_ctr === 1'b1) n_ctr++;
            if (c_rd_blk === 1'b1) begin rd_pulses++; rd_cyc = cyc; end
            if (bq.size() > 0) begin
                be = bq.pop_front();
                check("c_din", c_din, be.d);
                check("c_wr_key", c_wr_key, be.first && be.op == 2'd0);
                check("c_wr_nnc", c_wr_nnc, be.first && be.op == 2'd1);
                check("c_wr_ctr", c_wr_ctr, be.first && be.op == 2'd2);
                if (bcnt < 64) blog[bcnt] = c_din;
                bcnt++;
            end else begin
                check("c_din_idle", c_din, 0);
                check("strobes_idle", {c_wr_key, c_wr_nnc, c_wr_ctr}, 0);
            end
            if (oq.size() > 0) oe = oq.pop_front();
            else oe = '{v: 0, d: 8'h00, last: 0};
            check("out_valid", out_valid, oe.v);
            if (oe.v) begin
                check("out_data", out_data, oe.d);
                check("out_last", out_last, oe.last);
                if (ocnt < 64) olog[ocnt] = out_data;
                ocnt++;
            end
            if (!rst_n) begin
                bq.delete(); oq.delete(); pay.delete();
                in_fill = 0; waiting = 0; rd_next = 0; exp_err = 0;
            end else begin
                if (rd_next) begin
                    rd_next = 0;
                    oq.push_back('{v: 0, d: 8'h00, last: 0});
                    for (int k = 0; k < 64; k++)
                        oq.push_back('{v: 1, d: 8'(k) ^ 8'h5A, last: (k == 63)});
                end
                if (waiting) begin
                    wcnt++;
                    if (c_blk_rdy) begin waiting = 0; rd_next = 1; end
                    else if (wcnt == TO) begin waiting = 0; exp_err = 1; end
                end
                if (in_fill && in_valid) begin
                    pay.push_back(in_data);
                    if (pay.size() == plen(m_op)) begin
                        in_fill = 0;
                        for (int k = 0; k < pay.size(); k++)
                            bq.push_back('{d: pay[k], op: m_op, first: (k == 0)});
                        pay.delete();
                    end
                end
                if (!eb && cmd_valid) begin
                    exp_err = 0;
                    m_op = cmd_op;
                    acc_cyc = cyc;
                    bcnt = 0;
                    if (cmd_op == 2'd3) begin waiting = 1; wcnt = 0; ocnt = 0; end
                    else begin in_fill = 1; pay.delete(); end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
        check("cmd_accept_bound", n < 200, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b [32], input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (gaps) begin
                int g = $urandom_range(0, 2);
                in_valid = 1'b0;
                repeat (g) tick();
            end
            in_valid = 1'b1;
            in_data = b[i];
            while (in_ready !== 1'b1 && w < 50) begin tick(); w++; end
            check("in_accept_bound", w < 50, 1);
            tick();
        end
        in_valid = 1'b0;
        in_data = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 300) begin tick(); n++; end
        check("idle_bound", n < 300, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b [32];
        int n;
        rst_n = 0; cmd_valid = 0; cmd_op = 0; in_valid = 0; in_data = 0;
        pause = 0; c_blk_rdy = 0;
        tick(); tick();
        armed = 1;
        tick();
        rst_n = 1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_c_din", c_din, 0);
        check("rst_out_valid", out_valid, 0);

        // Key load with random host gaps
        for (int i = 0; i < 32; i++) b[i] = 8'(i);
        send_cmd(2'd0);
        send_bytes(b, 32, 1);
        wait_idle();
        check("key_len", bcnt, 32);
        check("key_b0", blog[0], 8'h00);
        check("key_b31", blog[31], 8'h1F);
        check("key_strobes", n_key, 1);

        // Nonce then counter
        for (int i = 0; i < 12; i++) b[i] = 8'hA0 + 8'(i);
        send_cmd(2'd1);
        send_bytes(b, 12, 0);
        wait_idle();
        check("nnc_len", bcnt, 12);
        check("nnc_b11", blog[11], 8'hAB);
        check("nnc_strobes", n_nnc, 1);
        b[0] = 8'h01; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
        send_cmd(2'd2);
        send_bytes(b, 4, 0);
        wait_idle();
        check("ctr_len", bcnt, 4);
        check("ctr_b0", blog[0], 8'h01);
        check("ctr_strobes", n_ctr, 1);
        check("key_strobes_still", n_key, 1);

        // Read block, with the next command held valid during the read
        send_cmd(2'd3);
        repeat (9) tick();
        c_blk_rdy = 1'b1;
        tick();
        c_blk_rdy = 1'b0;
        send_cmd(2'd0);
        check("rd_pulses", rd_pulses, 1);
        check("rd_bytes", ocnt, 64);
        check("rd_b0", olog[0], 8'h5A);
        check("rd_b1", olog[1], 8'h5B);
        check("rd_b63", olog[63], 8'h65);
        check("b2b_accept_gap", acc_cyc - rd_cyc, 65);

        // Key payload for the back-to-back command; pause toggles across the burst
        for (int i = 0; i < 32; i++) b[i] = 8'h40 + 8'(i);
        send_bytes(b, 32, 0);
        for (int i = 0; i < 40; i++) begin pause = ~pause; tick(); end
        pause = 1'b0;
        wait_idle();
        check("pause_len", bcnt, 32);
        check("pause_b0", blog[0], 8'h40);
        check("pause_b31", blog[31], 8'h5F);
        check("pause_key_strobes", n_key, 2);

        // Read timeout
        send_cmd(2'd3);
        n = 0;
        while (err !== 1'b1 && n < 40) begin tick(); n++; end
        check("timeout_cycles", n, TO);
        check("timeout_no_rd", rd_pulses, 1);
        check("timeout_idle", cmd_ready, 1);
        send_cmd(2'd2);
        check("err_cleared", err, 0);
        b[0] = 8'h07; b[1] = 8'h06; b[2] = 8'h05; b[3] = 8'h04;
        send_bytes(b, 4, 0);
        wait_idle();
        check("ctr2_b3", blog[3], 8'h04);

        // Reset during key byte 5 of a burst
        for (int i = 0; i < 32; i++) b[i] = 8'h10 + 8'(i);
        send_cmd(2'd0);
        send_bytes(b, 32, 0);
        repeat (5) tick();
        check("pre_rst_byte5", c_din, 8'h15);
        rst_n = 1'b0;
        tick();
        check("rst_mid_strobe", {c_wr_key, c_wr_nnc, c_wr_ctr}, 0);
        check("rst_mid_c_din", c_din, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) b[i] = 8'h80 + 8'(i);
        send_cmd(2'd0);
        send_bytes(b, 32, 1);
        wait_idle();
        check("fresh_len", bcnt, 32);
        check("fresh_b0", blog[0], 8'h80);
        check("fresh_b31", blog[31], 8'h9F);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
